// File: rtl/periph_bitband_sequencer.sv
// periph_bitband_sequencer
//
// Puts every core data access to the peripheral window onto the peripheral
// bus, one outstanding transaction at a time.
//   * Plain access: one bus transaction with the captured we/be/addr/wdata.
//   * Bit-band write: a locked read-modify-write of the aliased word. Only the
//     addressed bit is replaced by wdata[0].
//   * Bit-band read: a single bus read. The addressed bit is returned in
//     rdata[0].
//
// Handshake semantics, core and bus side alike: a request is transferred in
// the cycle where req and gnt are both high. The request side keeps its
// payload stable from raising req until that cycle. A response is a
// single-cycle rvalid pulse. On the bus side the pulse is only taken in a
// *_WAIT state, and so never in the same cycle as the grant.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   data_req_i / data_gnt_o  core request / grant (grant only in IDLE)
//   data_we_i, data_be_i     core write enable, byte enables
//   data_addr_i, data_wdata_i core byte address, write data
//   data_rvalid_o            core response pulse
//   data_rdata_o, data_err_o core read data, error (valid with rvalid)
//   periph_req_o / periph_gnt_i    bus request / grant
//   periph_we_o, periph_be_o       bus write enable, byte enables
//   periph_addr_o, periph_wdata_o  bus address, write data
//   periph_rvalid_i, periph_rdata_i, periph_err_i  bus response
//   periph_lock_o            held high across a bit-band read-modify-write
//   dbg_state_o              current FSM state encoding (debug)
module periph_bitband_sequencer #(
    parameter logic [31:0] PERIPH_BASE = 32'h0080_0000,
    parameter logic [31:0] BB_BASE     = 32'h0280_0000,
    parameter logic [31:0] BB_SIZE     = 32'h0002_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        periph_req_o,
    input  logic        periph_gnt_i,
    output logic        periph_we_o,
    output logic [3:0]  periph_be_o,
    output logic [31:0] periph_addr_o,
    output logic [31:0] periph_wdata_o,
    input  logic        periph_rvalid_i,
    input  logic [31:0] periph_rdata_i,
    input  logic        periph_err_i,
    output logic        periph_lock_o,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        P_REQ      = 3'd1,
        P_WAIT     = 3'd2,
        BB_RD_REQ  = 3'd3,
        BB_RD_WAIT = 3'd4,
        BB_WR_REQ  = 3'd5,
        BB_WR_WAIT = 3'd6,
        RESP       = 3'd7
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic        hit_q, hit_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] tgt_q, tgt_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] old_q, old_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Alias decode. The offset is computed first, so the upper bound check
    // cannot overflow even when BB_BASE + BB_SIZE would wrap.
    logic [31:0] bb_off;
    logic        bb_hit;
    logic [31:0] bb_tgt;
    logic [31:0] merged_word;

    always_comb begin
        bb_off = data_addr_i - BB_BASE;
        bb_hit = (data_addr_i >= BB_BASE) && (bb_off < BB_SIZE);
        // Each 128 alias bytes (32 bits x 4 bytes) map onto one 32-bit word.
        bb_tgt = PERIPH_BASE + {5'b0, bb_off[31:7], 2'b00};
    end

    always_comb begin
        merged_word        = old_q;
        merged_word[idx_q] = wdata_q[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            be_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            tgt_q   <= 32'h0;
            idx_q   <= 5'h0;
            old_q   <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            hit_q   <= hit_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tgt_q   <= tgt_d;
            idx_q   <= idx_d;
            old_q   <= old_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        hit_d   = hit_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tgt_d   = tgt_q;
        idx_d   = idx_q;
        old_d   = old_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        data_gnt_o     = 1'b0;
        data_rvalid_o  = 1'b0;
        data_rdata_o   = 32'h0;
        data_err_o     = 1'b0;
        periph_req_o   = 1'b0;
        periph_we_o    = 1'b0;
        periph_be_o    = 4'h0;
        periph_addr_o  = 32'h0;
        periph_wdata_o = 32'h0;
        periph_lock_o  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Masked during reset so that no request appears accepted
                // while the reset discards it.
                data_gnt_o = data_req_i && !rst;
                if (data_req_i) begin
                    we_d    = data_we_i;
                    be_d    = data_be_i;
                    addr_d  = data_addr_i;
                    wdata_d = data_wdata_i;
                    hit_d   = bb_hit;
                    tgt_d   = bb_tgt;
                    idx_d   = bb_off[6:2];
                    state_d = bb_hit ? BB_RD_REQ : P_REQ;
                end
            end
            P_REQ: begin
                periph_req_o   = 1'b1;
                periph_we_o    = we_q;
                periph_be_o    = be_q;
                periph_addr_o  = addr_q;
                periph_wdata_o = wdata_q;
                if (periph_gnt_i) state_d = P_WAIT;
            end
            P_WAIT: begin
                if (periph_rvalid_i) begin
                    rdata_d = we_q ? 32'h0 : periph_rdata_i;
                    err_d   = periph_err_i;
                    state_d = RESP;
                end
            end
            BB_RD_REQ: begin
                periph_req_o  = 1'b1;
                periph_be_o   = 4'hF;
                periph_addr_o = tgt_q;
                periph_lock_o = we_q;
                if (periph_gnt_i) state_d = BB_RD_WAIT;
            end
            BB_RD_WAIT: begin
                periph_lock_o = we_q;
                if (periph_rvalid_i) begin
                    old_d = periph_rdata_i;
                    if (periph_err_i) begin
                        // A failed read aborts the sequence: nothing is written.
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (we_q) begin
                        state_d = BB_WR_REQ;
                    end else begin
                        rdata_d = {31'b0, periph_rdata_i[idx_q]};
                        err_d   = 1'b0;
                        state_d = RESP;
                    end
                end
            end
            BB_WR_REQ: begin
                periph_req_o   = 1'b1;
                periph_we_o    = 1'b1;
                periph_be_o    = 4'hF;
                periph_addr_o  = tgt_q;
                periph_wdata_o = merged_word;
                periph_lock_o  = we_q;
                if (periph_gnt_i) state_d = BB_WR_WAIT;
            end
            BB_WR_WAIT: begin
                periph_lock_o = we_q;
                if (periph_rvalid_i) begin
                    rdata_d = 32'h0;
                    err_d   = periph_err_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                data_rvalid_o = 1'b1;
                data_rdata_o  = rdata_q;
                data_err_o    = err_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_state_o = state_q;

endmodule
